// File: rtl/jt6295_accn_if.sv
// rtl/jt6295_accn_if.sv - strobe/sample bus between the ADPCM voice engine and the channel accumulator
interface jt6295_accn_if #(
  parameter int CW = 2,
  parameter int IW = 12,
  parameter int OW = 14
);
  logic                 cen;
  logic                 cen4;
  logic [CW-1:0]        ch_in;
  logic signed [IW-1:0] sound_in;
  logic signed [OW-1:0] sound_out;
  logic                 sample;
  logic                 ovf;

  modport master (
    output cen, cen4, ch_in, sound_in,
    input  sound_out, sample, ovf
  );

  modport slave (
    input  cen, cen4, ch_in, sound_in,
    output sound_out, sample, ovf
  );
endinterface

// File: rtl/jt6295_accn.sv
// rtl/jt6295_accn.sv - per-channel accumulate, mix and decimate to one output sample per cen window
// Optional output saturation with overflow flag: define JT6295_ACCN_SAT_EN (default: wrap, ovf tied 0).
module jt6295_accn #(
  parameter int CH    = 4,
  parameter int IW    = 12,
  parameter int OW    = 14,
  parameter int MAXN  = 4,
  parameter int SHIFT = 0
)(
  input  logic          clk,
  input  logic          rst,
  jt6295_accn_if.slave  bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = IW + $clog2(MAXN) + $clog2(CH);
  localparam int FW = (AW > OW) ? AW : OW;
  localparam logic [CW:0] CH_L = (CW+1)'(CH);

  logic signed [AW-1:0] acc [CH];
  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] mix;
  logic signed [AW-1:0] shifted;
  logic signed [FW-1:0] wide;
  logic signed [OW-1:0] fmt;
  logic signed [OW-1:0] sound_out_r;
  logic [CH-1:0]        hit;
  logic                 ch_ok;
  logic                 s1_valid;
  logic                 sample_r;

  assign in_ext = AW'(bus.sound_in);
  assign ch_ok  = ({1'b0, bus.ch_in} < CH_L);

  // Out-of-range channel indices never hit, so they neither add nor load.
  always_comb begin
    hit = '0;
    for (int k = 0; k < CH; k++)
      hit[k] = bus.cen4 && ch_ok && (bus.ch_in == CW'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++)
        acc[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (bus.cen)
          acc[k] <= hit[k] ? in_ext : '0;
        else if (hit[k])
          acc[k] <= acc[k] + in_ext;
      end
    end
  end

  // Mix uses the accumulators as they stood before this edge's update.
  always_comb begin
    sum = '0;
    for (int k = 0; k < CH; k++)
      sum = sum + acc[k];
  end

  assign shifted = mix >>> SHIFT;
  assign wide    = FW'(shifted);

`ifdef JT6295_ACCN_SAT_EN
  logic [FW-OW:0] hi;
  logic           clip;
  logic           ovf_r;

  always_comb begin
    hi   = wide[FW-1:OW-1];
    clip = !((&hi) || !(|hi));
    fmt  = wide[OW-1:0];
    if (clip)
      fmt = wide[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_r <= 1'b0;
    else
      ovf_r <= s1_valid && clip;
  end

  assign bus.ovf = ovf_r;
`else
  assign fmt     = OW'(wide);
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      mix         <= '0;
      sound_out_r <= '0;
      sample_r    <= 1'b0;
    end else begin
      s1_valid <= bus.cen;
      sample_r <= s1_valid;
      if (bus.cen)
        mix <= sum;
      if (s1_valid)
        sound_out_r <= fmt;
    end
  end

  assign bus.sound_out = sound_out_r;
  assign bus.sample    = sample_r;
endmodule

// File: tb/tb_jt6295_accn.sv
// tb/tb_jt6295_accn.sv - directed bench for jt6295_accn (default, CH=3 and SHIFT=2 instances)
module tb_jt6295_accn;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  jt6295_accn_if #(.CW(2), .IW(12), .OW(14)) b0();
  jt6295_accn_if #(.CW(2), .IW(12), .OW(14)) b1();
  jt6295_accn_if #(.CW(2), .IW(12), .OW(14)) b2();

  jt6295_accn #(.CH(4), .IW(12), .OW(14), .MAXN(4), .SHIFT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  jt6295_accn #(.CH(3), .IW(12), .OW(14), .MAXN(4), .SHIFT(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  jt6295_accn #(.CH(4), .IW(12), .OW(14), .MAXN(4), .SHIFT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int out_of(input int sel);
    case (sel)
      0:       return int'(b0.sound_out);
      1:       return int'(b1.sound_out);
      default: return int'(b2.sound_out);
    endcase
  endfunction

  function automatic int smp_of(input int sel);
    case (sel)
      0:       return int'(b0.sample);
      1:       return int'(b1.sample);
      default: return int'(b2.sample);
    endcase
  endfunction

  function automatic int ovf_of(input int sel);
    case (sel)
      0:       return int'(b0.ovf);
      1:       return int'(b1.ovf);
      default: return int'(b2.ovf);
    endcase
  endfunction

  task automatic idle_all();
    b0.cen = 0; b0.cen4 = 0; b0.ch_in = 0; b0.sound_in = 0;
    b1.cen = 0; b1.cen4 = 0; b1.ch_in = 0; b1.sound_in = 0;
    b2.cen = 0; b2.cen4 = 0; b2.ch_in = 0; b2.sound_in = 0;
  endtask

  // One clk of stimulus on the selected bus; returns 1 time unit after the sampling edge.
  task automatic drive(input int sel, input bit c, input bit c4, input int ch, input int val);
    logic [1:0]  chv;
    logic [11:0] v;
    chv = ch[1:0];
    v   = val[11:0];
    case (sel)
      0: begin b0.cen = c; b0.cen4 = c4; b0.ch_in = chv; b0.sound_in = v; end
      1: begin b1.cen = c; b1.cen4 = c4; b1.ch_in = chv; b1.sound_in = v; end
      default: begin b2.cen = c; b2.cen4 = c4; b2.ch_in = chv; b2.sound_in = v; end
    endcase
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic push(input int sel, input int ch, input int val);
    drive(sel, 1'b0, 1'b1, ch, val);
  endtask

  task automatic close_win(input int sel);
    drive(sel, 1'b1, 1'b0, 0, 0);
  endtask

  // Called right after the cen edge: sample must be low now and high one edge later.
  task automatic expect_out(input int sel, input string tag, input int exp, input int exp_ovf);
    check({tag, "_pre"}, smp_of(sel), 0);
    @(posedge clk);
    #1;
    check({tag, "_smp"}, smp_of(sel), 1);
    check(tag, out_of(sel), exp);
    check({tag, "_ovf"}, ovf_of(sel), exp_ovf);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_out%0d", s), out_of(s), 0);
      check($sformatf("rst_smp%0d", s), smp_of(s), 0);
      check($sformatf("rst_ovf%0d", s), ovf_of(s), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four samples on ch0, then hold check
    push(0, 0, 100); push(0, 0, 200); push(0, 0, 300); push(0, 0, 400);
    close_win(0);
    expect_out(0, "t030", 1000, 0);
    @(posedge clk);
    #1;
    check("t030_smp_low", smp_of(0), 0);
    check("t030_hold", out_of(0), 1000);

    // cen coincident with cen4: mix sees old value, channel loads the new one
    push(0, 1, 70);
    drive(0, 1'b1, 1'b1, 1, 50);
    expect_out(0, "t031a", 70, 0);
    close_win(0);
    expect_out(0, "t031b", 50, 0);

    // cen pulses two clk apart
    push(0, 0, 5);
    close_win(0);
    push(0, 0, 7);
    check("b2b_smp1", smp_of(0), 1);
    check("b2b_out1", out_of(0), 5);
    close_win(0);
    check("b2b_gap", smp_of(0), 0);
    check("b2b_hold", out_of(0), 5);
    @(posedge clk);
    #1;
    check("b2b_smp2", smp_of(0), 1);
    check("b2b_out2", out_of(0), 7);

    // Full-scale positive and negative windows
    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 4; n++)
        push(0, c, 2047);
    close_win(0);
`ifdef JT6295_ACCN_SAT_EN
    expect_out(0, "t032p", 8191, 1);
`else
    expect_out(0, "t032p", -16, 0);
`endif
    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 4; n++)
        push(0, c, -2048);
    close_win(0);
`ifdef JT6295_ACCN_SAT_EN
    expect_out(0, "t032n", -8192, 1);
`else
    expect_out(0, "t032n", 0, 0);
`endif

    // 17 x 2047 on one channel wraps the 16-bit accumulator to -30737
    for (int n = 0; n < 17; n++)
      push(0, 0, 2047);
    close_win(0);
`ifdef JT6295_ACCN_SAT_EN
    expect_out(0, "wrap", -8192, 1);
`else
    expect_out(0, "wrap", 2031, 0);
`endif

    // CH=3: index 3 ignored for accumulate and for the cen load
    push(1, 3, 500);
    push(1, 0, 10);
    close_win(1);
    expect_out(1, "t033a", 10, 0);
    push(1, 2, 9);
    drive(1, 1'b1, 1'b1, 3, 500);
    expect_out(1, "t033b", 9, 0);
    close_win(1);
    expect_out(1, "t033c", 0, 0);

    // SHIFT=2: arithmetic floor
    push(2, 0, 1000);
    close_win(2);
    expect_out(2, "t035a", 250, 0);
    push(2, 1, -3);
    close_win(2);
    expect_out(2, "t035b", -1, 0);

    // Reset mid-window with a cen in flight
    push(0, 2, 300);
    push(0, 2, 300);
    close_win(0);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("t034_rst_smp%0d", n), smp_of(0), 0);
      check($sformatf("t034_rst_out%0d", n), out_of(0), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, 2, 5);
    close_win(0);
    expect_out(0, "t034", 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
